// File: rtl/fetch_aligner_pkg.sv
// Core-wide fetch constants and the compressed-instruction detect helper.
package fetch_aligner_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int          HW_W         = 16;
  localparam logic [1:0]  OPC_FULL     = 2'b11;

  typedef logic [HW_W-1:0] hw_t;

  function automatic logic is_compressed(input hw_t hw);
    return hw[1:0] != OPC_FULL;
  endfunction

endpackage

// File: rtl/fetch_aligner_hw_queue.sv
// Four-entry halfword shift queue: pop 0/1/2 from the head, push 0/1/2 behind the survivors, flush.
// Registered contents; caller guarantees that pushes never exceed the free space.
module fetch_aligner_hw_queue
  import fetch_aligner_pkg::*;
(
  input  logic       clk,
  input  logic       i_rst_n,
  input  logic       i_flush,
  input  logic [1:0] i_pop_n,
  input  logic [1:0] i_push_n,
  input  hw_t        i_push_lo,
  input  hw_t        i_push_hi,
  output hw_t        o_q0,
  output hw_t        o_q1,
  output logic [2:0] o_count
);

  hw_t        r_q [4];
  logic [2:0] r_count;

  hw_t        w_shift [4];
  hw_t        w_next  [4];
  logic [2:0] w_base;

  always_comb begin
    for (int i = 0; i < 4; i++) w_shift[i] = '0;
    case (i_pop_n)
      2'd0: begin
        for (int i = 0; i < 4; i++) w_shift[i] = r_q[i];
      end
      2'd1: begin
        w_shift[0] = r_q[1];
        w_shift[1] = r_q[2];
        w_shift[2] = r_q[3];
      end
      default: begin
        w_shift[0] = r_q[2];
        w_shift[1] = r_q[3];
      end
    endcase

    // New halfwords land directly behind whatever survives this cycle's pop.
    w_base = r_count - {1'b0, i_pop_n};
    for (int i = 0; i < 4; i++) w_next[i] = w_shift[i];
    if (i_push_n != 2'd0) w_next[w_base[1:0]] = i_push_lo;
    if (i_push_n == 2'd2) w_next[w_base[1:0] + 2'd1] = i_push_hi;
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 4; i++) r_q[i] <= '0;
      r_count <= '0;
    end else begin
      for (int i = 0; i < 4; i++) r_q[i] <= w_next[i];
      r_count <= i_flush ? 3'd0 : (r_count - {1'b0, i_pop_n} + {1'b0, i_push_n});
    end
  end

  assign o_q0    = r_q[0];
  assign o_q1    = r_q[1];
  assign o_count = r_count;

endmodule

// File: rtl/fetch_aligner.sv
// RV32IC fetch aligner: word fetches in, one 16/32-bit instruction per decode handshake out.
// Issue is combinational from the registered queue (response in cycle N issues in N+1); decode stall throttles fetch.
module fetch_aligner
  import fetch_aligner_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          DEPTH_HW = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_valid,
  input  logic [31:0] mem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic        instr_is_c,
  output logic [31:0] instr_pc
);

  localparam logic [2:0] REQ_MAX = 3'(DEPTH_HW - 2);

  logic [31:0] r_head_pc;
  logic [31:0] r_fetch_addr;
  logic        r_outstanding;
  logic        r_drop_resp;
  logic        r_skip_low;

  hw_t         w_q0;
  hw_t         w_q1;
  logic [2:0]  w_count;
  logic [2:0]  w_count_after_pop;
  logic        w_is_c;
  logic        w_valid;
  logic        w_pop;
  logic [1:0]  w_pop_n;
  logic        w_resp;
  logic [1:0]  w_push_n;
  hw_t         w_push_lo;
  hw_t         w_push_hi;

  assign w_is_c            = is_compressed(w_q0);
  assign w_valid           = w_is_c ? (w_count >= 3'd1) : (w_count >= 3'd2);
  assign w_pop             = w_valid && instr_ready && !redirect;
  assign w_pop_n           = !w_pop ? 2'd0 : (w_is_c ? 2'd1 : 2'd2);
  assign w_count_after_pop = w_count - {1'b0, w_pop_n};
  assign w_resp            = mem_valid && r_outstanding;

  // Gated by rst so the request pulse is low while reset is held.
  assign mem_req  = rst && !r_outstanding && !redirect && (w_count_after_pop <= REQ_MAX);
  assign mem_addr = mem_req ? r_fetch_addr : '0;

  always_comb begin
    w_push_n  = 2'd0;
    w_push_lo = mem_rdata[15:0];
    w_push_hi = mem_rdata[31:16];
    if (w_resp && !redirect && !r_drop_resp) begin
      if (r_skip_low) begin
        w_push_n  = 2'd1;
        w_push_lo = mem_rdata[31:16];
      end else begin
        w_push_n  = 2'd2;
      end
    end
  end

  fetch_aligner_hw_queue u_queue (
    .clk       (clk),
    .i_rst_n   (rst),
    .i_flush   (redirect),
    .i_pop_n   (w_pop_n),
    .i_push_n  (w_push_n),
    .i_push_lo (w_push_lo),
    .i_push_hi (w_push_hi),
    .o_q0      (w_q0),
    .o_q1      (w_q1),
    .o_count   (w_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head_pc     <= RESET_PC & ~32'd1;
      r_fetch_addr  <= RESET_PC & ~32'd3;
      r_outstanding <= 1'b0;
      r_drop_resp   <= 1'b0;
      r_skip_low    <= 1'b0;
    end else if (redirect) begin
      r_head_pc     <= redirect_pc & ~32'd1;
      r_fetch_addr  <= redirect_pc & ~32'd3;
      r_skip_low    <= redirect_pc[1];
      // A response landing in the redirect cycle retires the old request outright.
      r_outstanding <= r_outstanding && !mem_valid;
      r_drop_resp   <= r_outstanding && !mem_valid;
    end else begin
      if (w_pop) r_head_pc <= r_head_pc + (w_is_c ? 32'd2 : 32'd4);
      if (mem_req) begin
        r_fetch_addr  <= r_fetch_addr + 32'd4;
        r_outstanding <= 1'b1;
      end else if (w_resp) begin
        r_outstanding <= 1'b0;
        r_drop_resp   <= 1'b0;
        if (!r_drop_resp) r_skip_low <= 1'b0;
      end
    end
  end

  assign instr_valid = w_valid;
  assign instr_is_c  = w_valid && w_is_c;
  assign instr       = !w_valid ? '0 : (w_is_c ? {16'h0000, w_q0} : {w_q1, w_q0});
  assign instr_pc    = w_valid ? r_head_pc : '0;

endmodule
